// File: rtl/hms_pkg.sv
// hms_pkg: shared types, digit limits and load validation for hms_timer.
package hms_pkg;
  localparam int UNITS_W = 4;
  localparam int TENS_W = 3;
  localparam int HT_W = 2;
  localparam int UNITS_MAX = 9;
  localparam int TENS_MAX = 5;
  typedef struct packed {
    logic [HT_W-1:0] h_tens;
    logic [UNITS_W-1:0] h_units;
    logic [TENS_W-1:0] m_tens;
    logic [UNITS_W-1:0] m_units;
    logic [TENS_W-1:0] s_tens;
    logic [UNITS_W-1:0] s_units;
  } time_bcd_t;
  typedef enum logic [1:0] {STOP, RUN, EXPIRED} state_t;
  function automatic logic time_valid(time_bcd_t t, int hour_mod);
    return int'(t.s_units) <= UNITS_MAX && int'(t.s_tens) <= TENS_MAX &&
           int'(t.m_units) <= UNITS_MAX && int'(t.m_tens) <= TENS_MAX &&
           int'(t.h_units) <= UNITS_MAX &&
           int'(t.h_tens) * 10 + int'(t.h_units) < hour_mod;
  endfunction
endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one up/down BCD digit with load and an optional run-time limit override.
module bcd_digit_cnt #(
  parameter int WIDTH = 4,
  parameter int MAX = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             lim_en,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             carry
);
  logic [WIDTH-1:0] top;
  assign top = lim_en ? lim : WIDTH'(MAX);
  assign carry = step & (down ? q == '0 : q == top);
  always_comb
    nxt = load ? load_val : !step ? q :
          down ? (q == '0 ? top : q - 1'b1) : (q == top ? '0 : q + 1'b1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/hms_timer.sv
// hms_timer: HH:MM:SS BCD up/down timer with tick prescaler, run/stop, validated load.
// Optional alarm compare output is enabled with `define HMS_TIMER_ALARM_EN.
module hms_timer
  import hms_pkg::*;
#(
  parameter int HOUR_MOD = 24,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_en,
  input  logic        run,
  input  logic        down,
  input  logic        load_valid,
  input  logic [19:0] load_time,
`ifdef HMS_TIMER_ALARM_EN
  input  logic [19:0] alarm_time,
  output logic        alarm,
`endif
  output logic        load_ready,
  output logic        load_err,
  output logic [19:0] time_bcd,
  output logic        rollover,
  output logic        expired
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam int HT_MAX = (HOUR_MOD - 1) / 10;
  localparam logic [UNITS_W-1:0] HU_LIM = UNITS_W'((HOUR_MOD - 1) % 10);
  state_t state, state_nxt;
  logic [PW-1:0] pre;
  time_bcd_t t, nx, lt;
  logic [5:0] c;
  logic accept, ld, zero, do_step;
  assign lt = load_time;
  assign accept = load_valid & load_ready;
  assign ld = accept & time_valid(lt, HOUR_MOD);
  assign zero = t == '0;
  assign do_step = state == RUN & tick_en & pre == PRE_LAST & ~accept & ~(down & zero);
  assign time_bcd = t;
  bcd_digit_cnt #(.WIDTH(UNITS_W), .MAX(UNITS_MAX)) u_su (.clk(clk), .reset(reset), .step(do_step), .down(down),
    .load(ld), .load_val(lt.s_units), .lim_en(1'b0), .lim('0), .q(t.s_units), .nxt(nx.s_units), .carry(c[0]));
  bcd_digit_cnt #(.WIDTH(TENS_W), .MAX(TENS_MAX)) u_st (.clk(clk), .reset(reset), .step(c[0]), .down(down),
    .load(ld), .load_val(lt.s_tens), .lim_en(1'b0), .lim('0), .q(t.s_tens), .nxt(nx.s_tens), .carry(c[1]));
  bcd_digit_cnt #(.WIDTH(UNITS_W), .MAX(UNITS_MAX)) u_mu (.clk(clk), .reset(reset), .step(c[1]), .down(down),
    .load(ld), .load_val(lt.m_units), .lim_en(1'b0), .lim('0), .q(t.m_units), .nxt(nx.m_units), .carry(c[2]));
  bcd_digit_cnt #(.WIDTH(TENS_W), .MAX(TENS_MAX)) u_mt (.clk(clk), .reset(reset), .step(c[2]), .down(down),
    .load(ld), .load_val(lt.m_tens), .lim_en(1'b0), .lim('0), .q(t.m_tens), .nxt(nx.m_tens), .carry(c[3]));
  // Down-count borrows into hour units always decrement h_tens, so the short limit applies only counting up.
  bcd_digit_cnt #(.WIDTH(UNITS_W), .MAX(UNITS_MAX)) u_hu (.clk(clk), .reset(reset), .step(c[3]), .down(down),
    .load(ld), .load_val(lt.h_units), .lim_en(~down & int'(t.h_tens) == HT_MAX), .lim(HU_LIM),
    .q(t.h_units), .nxt(nx.h_units), .carry(c[4]));
  bcd_digit_cnt #(.WIDTH(HT_W), .MAX(HT_MAX)) u_ht (.clk(clk), .reset(reset), .step(c[4]), .down(down),
    .load(ld), .load_val(lt.h_tens), .lim_en(1'b0), .lim('0), .q(t.h_tens), .nxt(nx.h_tens), .carry(c[5]));
  always_comb
    state_nxt = accept ? STOP :
                state == STOP ? (run ? (down && zero ? EXPIRED : RUN) : STOP) :
                !run ? STOP :
                do_step && down && nx == '0 ? EXPIRED : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= STOP;
      pre <= '0;
      load_ready <= 1'b0;
      load_err <= 1'b0;
      rollover <= 1'b0;
      expired <= 1'b0;
    end else begin
      state <= state_nxt;
      pre <= (accept || state != RUN) ? '0 : tick_en ? (pre == PRE_LAST ? '0 : pre + 1'b1) : pre;
      load_ready <= ~accept;
      load_err <= accept & ~time_valid(lt, HOUR_MOD);
      rollover <= c[5] & ~down;
      expired <= state_nxt == EXPIRED;
    end
`ifdef HMS_TIMER_ALARM_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) alarm <= 1'b0;
    else alarm <= do_step & (nx == alarm_time);
`endif
endmodule

// File: tb/tb_hms_timer.sv
// tb_hms_timer: randomized and directed checks of hms_timer against a seconds-based reference model.
module tb_hms_timer;
  localparam int PRE = 3;
  localparam int MOD = 24;
  localparam int DAY = MOD * 3600;
  localparam int S_STOP = 0, S_RUN = 1, S_EXP = 2;
  logic clk = 0, reset = 0, tick_en = 0, run = 0, down = 0, load_valid = 0;
  logic [19:0] load_time = 0, time_bcd;
  logic load_ready, load_err, rollover, expired;
  logic run_b = 0, tick_b = 0, down_b = 0, lv_b = 0;
  logic [19:0] lt_b = 0, time_b;
  logic ready_b, err_b, roll_b, exp_b;
`ifdef HMS_TIMER_ALARM_EN
  logic [19:0] alarm_time = 0, alarm_time_b = 0;
  logic alarm, alarm_b;
`endif
  int errors = 0, checks = 0;
  int m_sec, m_state, m_pre, al_sec = -1;
  logic m_ready, m_err, m_roll, m_exp, m_alarm;

  always #5 clk = ~clk;

  hms_timer #(.HOUR_MOD(MOD), .PRESCALE(PRE)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .run(run), .down(down),
    .load_valid(load_valid), .load_time(load_time),
`ifdef HMS_TIMER_ALARM_EN
    .alarm_time(alarm_time), .alarm(alarm),
`endif
    .load_ready(load_ready), .load_err(load_err), .time_bcd(time_bcd),
    .rollover(rollover), .expired(expired));

  hms_timer #(.HOUR_MOD(12), .PRESCALE(1)) dut_b (
    .clk(clk), .reset(reset), .tick_en(tick_b), .run(run_b), .down(down_b),
    .load_valid(lv_b), .load_time(lt_b),
`ifdef HMS_TIMER_ALARM_EN
    .alarm_time(alarm_time_b), .alarm(alarm_b),
`endif
    .load_ready(ready_b), .load_err(err_b), .time_bcd(time_b),
    .rollover(roll_b), .expired(exp_b));

  function automatic logic [19:0] mk(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction
  function automatic int to_sec(logic [19:0] v);
    return (int'(v[19:18]) * 10 + int'(v[17:14])) * 3600 +
           (int'(v[13:11]) * 10 + int'(v[10:7])) * 60 + int'(v[6:4]) * 10 + int'(v[3:0]);
  endfunction
  function automatic logic [19:0] to_bcd(int s);
    return mk(s / 3600, (s / 60) % 60, s % 60);
  endfunction
  function automatic bit valid(logic [19:0] v, int hmod);
    return v[3:0] <= 9 && v[6:4] <= 5 && v[10:7] <= 9 && v[13:11] <= 5 && v[17:14] <= 9 &&
           int'(v[19:18]) * 10 + int'(v[17:14]) < hmod;
  endfunction
  function automatic logic [23:0] obs();
    return {time_bcd, load_ready, load_err, rollover, expired};
  endfunction
  function automatic logic [23:0] expv();
    return {to_bcd(m_sec), m_ready, m_err, m_roll, m_exp};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_state = S_STOP; m_pre = 0;
    m_ready = 0; m_err = 0; m_roll = 0; m_exp = 0; m_alarm = 0;
  endtask

  // Timer behaviour expressed as whole seconds since midnight.
  task automatic model_edge();
    bit acc, stp;
    int nsec;
    acc = load_valid && m_ready;
    stp = m_state == S_RUN && tick_en && m_pre == PRE - 1 && !acc && !(down && m_sec == 0);
    nsec = m_sec;
    m_roll = 0;
    m_alarm = 0;
    if (acc && valid(load_time, MOD)) nsec = to_sec(load_time);
    else if (stp) begin
      nsec = down ? m_sec - 1 : (m_sec + 1) % DAY;
      m_roll = !down && nsec == 0;
      m_alarm = nsec == al_sec;
    end
    m_err = acc && !valid(load_time, MOD);
    m_ready = !acc;
    if (acc || m_state != S_RUN) m_pre = 0;
    else if (tick_en) m_pre = (m_pre + 1) % PRE;
    if (acc) m_state = S_STOP;
    else if (m_state == S_STOP) m_state = run ? (down && m_sec == 0 ? S_EXP : S_RUN) : S_STOP;
    else if (!run) m_state = S_STOP;
    else if (stp && down && nsec == 0) m_state = S_EXP;
    m_sec = nsec;
    m_exp = m_state == S_EXP;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic go(int n, logic te);
    repeat (n) begin
      tick_en = te;
      cyc();
    end
    tick_en = 0;
  endtask

  task automatic idle();
    tick_en = 0; load_valid = 0; down = 0;
    cyc();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (obs() !== 24'h0) begin errors++; $display("FAIL reset_state got=%h exp=000000", obs()); end
    @(negedge clk);
    reset = 1;
    cyc();
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", load_ready); end
  endtask

  task automatic test_prescale();
    run = 1; down = 0;
    cyc();
    for (int i = 0; i < 9; i++) begin
      go(1, 1);
      go(1, 0);
    end
    checks++;
    if (time_bcd !== mk(0, 0, 3)) begin errors++; $display("FAIL prescale_9ticks got=%h exp=%h", time_bcd, mk(0, 0, 3)); end
    go(1, 1);
    run = 0;
    cyc();
    go(4, 1);
    run = 1;
    cyc();
    go(2, 1);
    checks++;
    if (time_bcd !== mk(0, 0, 3)) begin errors++; $display("FAIL prescale_held_in_stop got=%h exp=%h", time_bcd, mk(0, 0, 3)); end
    go(1, 1);
    checks++;
    if (obs() !== expv() || time_bcd !== mk(0, 0, 4)) begin errors++; $display("FAIL prescale_resume got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_rollover();
    int nroll;
    nroll = 0;
    load_time = mk(23, 59, 58); load_valid = 1; run = 1; down = 0;
    cyc();
    load_valid = 0;
    checks++;
    if (time_bcd !== mk(23, 59, 58) || load_ready !== 1'b0) begin errors++; $display("FAIL load_2359 got=%h rdy=%b exp=%h rdy=0", time_bcd, load_ready, mk(23, 59, 58)); end
    cyc();
    for (int i = 0; i < 12; i++) begin
      tick_en = 1;
      cyc();
      nroll += int'(rollover);
      checks++;
      if (obs() !== expv() || (rollover && time_bcd !== 20'h0)) begin errors++; $display("FAIL rollover_cycle%0d got=%h exp=%h", i, obs(), expv()); end
    end
    tick_en = 0;
    checks++;
    if (nroll != 1 || time_bcd !== mk(0, 0, 2)) begin errors++; $display("FAIL rollover_count got=%0d/%h exp=1/%h", nroll, time_bcd, mk(0, 0, 2)); end
  endtask

  task automatic test_load_err();
    load_time = mk(24, 0, 0); load_valid = 1; run = 0;
    cyc();
    load_valid = 0;
    checks++;
    if (load_err !== 1'b1 || time_bcd !== mk(0, 0, 2)) begin errors++; $display("FAIL load_err_hour got=%b/%h exp=1/%h", load_err, time_bcd, mk(0, 0, 2)); end
    cyc();
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_pulse got=%b exp=0", load_err); end
    go(6, 1);
    checks++;
    if (time_bcd !== mk(0, 0, 2)) begin errors++; $display("FAIL load_err_stop got=%h exp=%h", time_bcd, mk(0, 0, 2)); end
    load_time = mk(12, 34, 50);
    load_time[3:0] = 4'hA;
    load_valid = 1;
    cyc();
    load_valid = 0;
    checks++;
    if (load_err !== 1'b1 || time_bcd !== mk(0, 0, 2)) begin errors++; $display("FAIL load_err_digit got=%b/%h exp=1/%h", load_err, time_bcd, mk(0, 0, 2)); end
    cyc();
    load_time = mk(12, 34, 56); load_valid = 1;
    cyc();
    load_valid = 0;
    checks++;
    if (time_bcd !== mk(12, 34, 56) || load_err !== 1'b0) begin errors++; $display("FAIL load_ok got=%b/%h exp=0/%h", load_err, time_bcd, mk(12, 34, 56)); end
    for (int i = 0; i < 16; i++) begin
      load_time = (i % 2 == 0) ? 20'($urandom) : mk($urandom_range(0, 25), $urandom_range(0, 59), $urandom_range(0, 59));
      load_valid = 1;
      cyc();
      load_valid = 0;
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL load_rand%0d got=%h exp=%h", i, obs(), expv()); end
      cyc();
    end
  endtask

  task automatic test_down();
    idle();
    load_time = mk(0, 1, 0); load_valid = 1; run = 1; down = 1;
    cyc();
    load_valid = 0;
    cyc();
    go(179, 1);
    checks++;
    if (time_bcd !== mk(0, 0, 1) || expired !== 1'b0) begin errors++; $display("FAIL down_before_zero got=%h/%b exp=%h/0", time_bcd, expired, mk(0, 0, 1)); end
    go(1, 1);
    checks++;
    if (time_bcd !== 20'h0 || expired !== 1'b1) begin errors++; $display("FAIL down_expire got=%h/%b exp=0/1", time_bcd, expired); end
    go(9, 1);
    checks++;
    if (obs() !== expv() || time_bcd !== 20'h0 || expired !== 1'b1) begin errors++; $display("FAIL expired_hold got=%h exp=%h", obs(), expv()); end
    run = 0;
    cyc();
    checks++;
    if (expired !== 1'b0) begin errors++; $display("FAIL expired_clear got=%b exp=0", expired); end
  endtask

  task automatic test_collision();
    idle();
    load_time = mk(0, 0, 5); load_valid = 1; run = 1;
    cyc();
    load_valid = 0;
    cyc();
    go(2, 1);
    tick_en = 1; load_valid = 1; load_time = mk(7, 8, 9);
    cyc();
    tick_en = 0; load_valid = 0;
    checks++;
    if (time_bcd !== mk(7, 8, 9) || load_ready !== 1'b0) begin errors++; $display("FAIL collision_load got=%h/%b exp=%h/0", time_bcd, load_ready, mk(7, 8, 9)); end
    cyc();
    checks++;
    if (obs() !== expv() || load_ready !== 1'b1 || time_bcd !== mk(7, 8, 9)) begin errors++; $display("FAIL collision_after got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick_en = 1'($urandom);
      run = ($urandom % 16) != 0;
      if ($urandom % 32 == 0) down = ~down;
      load_valid = ($urandom % 24) == 0;
      case ($urandom_range(0, 3))
        0: load_time = mk(23, 59, $urandom_range(50, 59));
        1: load_time = mk(0, 0, $urandom_range(0, 9));
        2: load_time = mk($urandom_range(0, 25), $urandom_range(0, 59), $urandom_range(0, 59));
        default: load_time = 20'($urandom);
      endcase
      cyc();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random_cycle%0d got=%h exp=%h", i, obs(), expv()); end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    load_time = mk(0, 0, 41); load_valid = 1; run = 1;
    cyc();
    load_valid = 0;
    cyc();
    go(3, 1);
    checks++;
    if (time_bcd !== mk(0, 0, 42)) begin errors++; $display("FAIL reach_42 got=%h exp=%h", time_bcd, mk(0, 0, 42)); end
    tick_en = 1;
    #3 reset = 0;
    #1;
    checks++;
    if (obs() !== 24'h0) begin errors++; $display("FAIL async_reset got=%h exp=000000", obs()); end
    model_reset();
    tick_en = 0;
    @(negedge clk);
    reset = 1;
    cyc();
    checks++;
    if (obs() !== expv() || load_ready !== 1'b1) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs(), expv()); end
    run = 0;
    cyc();
  endtask

  task automatic test_hour12();
    lt_b = mk(11, 59, 59); lv_b = 1; run_b = 1;
    @(posedge clk); #1;
    lv_b = 0;
    checks++;
    if (time_b !== mk(11, 59, 59)) begin errors++; $display("FAIL h12_load got=%h exp=%h", time_b, mk(11, 59, 59)); end
    @(posedge clk); #1;
    tick_b = 1;
    @(posedge clk); #1;
    tick_b = 0;
    checks++;
    if (time_b !== 20'h0 || roll_b !== 1'b1) begin errors++; $display("FAIL h12_wrap got=%h/%b exp=0/1", time_b, roll_b); end
    @(posedge clk); #1;
    checks++;
    if (roll_b !== 1'b0) begin errors++; $display("FAIL h12_roll_pulse got=%b exp=0", roll_b); end
    lt_b = mk(12, 0, 0); lv_b = 1; run_b = 0;
    @(posedge clk); #1;
    lv_b = 0;
    checks++;
    if (err_b !== 1'b1 || time_b !== 20'h0) begin errors++; $display("FAIL h12_load_err got=%b/%h exp=1/0", err_b, time_b); end
    tick_b = 1;
    repeat (2) @(posedge clk);
    #1 tick_b = 0;
    checks++;
    if (time_b !== 20'h0 || err_b !== 1'b0) begin errors++; $display("FAIL h12_stop got=%h/%b exp=0/0", time_b, err_b); end
  endtask

`ifdef HMS_TIMER_ALARM_EN
  task automatic test_alarm();
    int n;
    n = 0;
    idle();
    al_sec = 2; alarm_time = mk(0, 0, 2);
    load_time = mk(0, 0, 0); load_valid = 1; run = 1;
    cyc();
    load_valid = 0;
    cyc();
    for (int i = 0; i < 12; i++) begin
      tick_en = 1;
      cyc();
      n += int'(alarm);
      checks++;
      if (alarm !== m_alarm || (alarm && time_bcd !== mk(0, 0, 2))) begin errors++; $display("FAIL alarm_cycle%0d got=%b exp=%b", i, alarm, m_alarm); end
    end
    tick_en = 0;
    checks++;
    if (n != 1) begin errors++; $display("FAIL alarm_count got=%0d exp=1", n); end
    load_time = mk(0, 0, 2); load_valid = 1;
    cyc();
    load_valid = 0;
    checks++;
    if (alarm !== 1'b0 || time_bcd !== mk(0, 0, 2)) begin errors++; $display("FAIL alarm_on_load got=%b/%h exp=0/%h", alarm, time_bcd, mk(0, 0, 2)); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_prescale();
    test_rollover();
    test_load_err();
    test_down();
    test_collision();
    test_random();
    test_reset_mid();
    test_hour12();
`ifdef HMS_TIMER_ALARM_EN
    test_alarm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hms_timer.md
Name: hms_timer

Overview:
- Parametrised hours:minutes:seconds BCD timer; next generation of the team's minute/second day timer.
- Adds an hour field with configurable modulus, up/down counting, and a tick prescaler driven by an external strobe.
- Adds run/stop control, a validated load handshake, and rollover/expiry flags.
- Sits between the board tick generator and the 7-segment display driver.

Parameters:
- HOUR_MOD, 24, hour modulus; legal 2..24. Hours count 0..HOUR_MOD-1.
- PRESCALE, 1, number of tick_en pulses per one-second step; legal 1..1024.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-low
- tick_en  input  1  one-cycle strobe from the tick generator
- run  input  1  level; 1 = count, 0 = hold
- down  input  1  direction; 0 = up, 1 = down
- load_valid  input  1  load request
- load_time  input  20  BCD time to load, layout hms_pkg::time_bcd_t
- load_ready  output  1  load accepted when load_valid & load_ready
- load_err  output  1  one-cycle pulse; accepted load was out of range
- time_bcd  output  20  current time {h_tens[1:0], h_units[3:0], m_tens[2:0], m_units[3:0], s_tens[2:0], s_units[3:0]}
- rollover  output  1  one-cycle pulse on up-count wrap to 00:00:00
- expired  output  1  level; high while in state EXPIRED

Behaviour:
- Reset (reset=0, asynchronous): time_bcd=0, state STOP, prescaler=0, load_ready=0, load_err=0, rollover=0, expired=0.
- First clk edge after reset release sets load_ready=1.
- All outputs are registered.
- States:
  - STOP: time holds; prescaler held at 0.
  - RUN: counting.
  - EXPIRED: time holds at 00:00:00; expired=1.
- Transitions:
  - STOP->RUN when run=1, unless down=1 and time==0; in that case STOP->EXPIRED.
  - RUN->STOP when run=0.
  - EXPIRED->STOP when run=0.
- Step:
  - In RUN, each tick_en increments the prescaler.
  - On the edge where tick_en=1 and prescaler==PRESCALE-1: prescaler<=0 and time steps by one second on that same edge.
  - tick_en in STOP or EXPIRED is ignored.
- Up count:
  - s_units 0..9, s_tens 0..5, m_units 0..9, m_tens 0..5.
  - Hours wrap from HOUR_MOD-1 to 00.
  - Hour-units limit is 9, except when h_tens equals the tens digit of HOUR_MOD-1; then the limit is the units digit of HOUR_MOD-1.
  - Wrap from max time to 00:00:00 sets rollover=1 for exactly the cycle in which time_bcd first shows 0; state stays RUN.
- Down count:
  - Digits borrow symmetrically; 00:00:00 is never decremented.
  - Step 00:00:01->00:00:00 moves to EXPIRED on the same edge; expired rises with time_bcd=0.
- down may change at any cycle; it takes effect on the next step only.
- Load handshake:
  - Accept when load_valid & load_ready.
  - On the accept edge: load_ready<=0 for exactly one cycle; prescaler<=0; state<=STOP; run must still be high to re-enter RUN on the following edge.
- Load validation:
  - Valid digits: units<=9, s_tens<=5, m_tens<=5, hours<HOUR_MOD.
  - Valid load: time_bcd<=load_time.
  - Invalid load: time unchanged; load_err pulses 1 cycle; state still forced to STOP.
- Simultaneous load accept and step: load wins; the step is dropped.
- Reset asserted mid-count: immediate clear; no rollover or expired pulse is generated.

Optional Feature:
- Macro HMS_TIMER_ALARM_EN.
- When defined, add ports alarm_time (input, 20) and alarm (output, 1).
- alarm pulses for one cycle on the edge where a step produces time_bcd==alarm_time, in either direction.
- Loads never trigger alarm; alarm resets to 0.
- When undefined, neither port exists and the logic is absent.

Decomposition:
- Package hms_pkg:
  - typedef struct packed time_bcd_t with the digit fields above.
  - enum state_t {STOP, RUN, EXPIRED}.
  - Constants for digit widths and per-digit maxima (9, 5).
  - function time_valid(time_bcd_t, hour_mod).
- Sub-module bcd_digit_cnt, instantiated six times:
  - Parameters MAX and WIDTH.
  - Inputs: step, down, load, load_val, limit override.
  - Output: digit value.
  - Output carry/borrow: asserted when the digit wraps.

Test Plan:
- PRESCALE=3, up, run=1 from 00:00:00: 9 tick_en pulses -> time_bcd shows 00:00:03; prescaler does not advance in STOP.
- HOUR_MOD=24: load 23:59:58, up, 2 steps -> 23:59:59 then 00:00:00; rollover high exactly 1 cycle.
- HOUR_MOD=12: load 11:59:59, one step -> 00:00:00. Load 12:00:00 -> load_err pulse, time unchanged, state STOP.
- Down from 00:01:00: 60 steps -> 00:00:00, expired=1; further ticks hold time. Drop run -> STOP, expired=0.
- load_valid in the same cycle as a qualifying tick with 00:00:05 -> loaded value appears, no step; load_ready low 1 cycle. Reset mid-count at 00:00:42 -> all outputs 0 asynchronously.
- With HMS_TIMER_ALARM_EN, alarm_time=00:00:02, up from 0 -> alarm pulses once on the step to 00:00:02; loading 00:00:02 does not pulse alarm.
